keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner -- column-scanning decoder for a Pmod KYPD 4x4 keypad.
//
// Drives one column low at a time, waits for the lines to settle, samples the
// synchronized rows and debounces both the press and the release of the first
// key found. An accepted press gives a one-cycle key_valid strobe. key_code
// holds the mapped hex value of that key until the next strobe. key_down stays
// high while the key is held.
//
// Optional feature: define KYPD_REPEAT_EN to enable auto-repeat. While a key
// stays held, key_valid pulses again every REPEAT_CYC cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   row_n[3:0] in   keypad rows, pulled up, low = pressed
//   col_n[3:0] out  column drives, exactly one bit low
//   key_valid  out  one-cycle strobe per accepted keypress (or repeat)
//   key_code   out  hex code of the last accepted key
//   key_down   out  high while the accepted key is held
module keypad_scanner #(
    parameter int SETTLE_CYC   = 1000,
    parameter int DEBOUNCE_CYC = 2000000,
    parameter int REPEAT_CYC   = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    localparam int SW = (SETTLE_CYC   > 1) ? $clog2(SETTLE_CYC + 1)   : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [3:0]    row_meta_r, row_sync_r;
    logic [1:0]    col_r, col_s;
    logic [1:0]    row_sel_r, row_sel_s;
    logic [SW-1:0] settle_cnt_r, settle_s;
    logic [DW-1:0] deb_cnt_r, deb_s;
    logic [3:0]    col_n_r;
    logic          key_valid_r, valid_s;
    logic [3:0]    key_code_r, code_s;
    logic          key_down_r, down_s;
    logic [3:0]    row_low_s;
    logic          sel_low_s;

`ifdef KYPD_REPEAT_EN
    localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC + 1) : 1;
    logic [RW-1:0] rep_cnt_r, rep_s;
`endif

    // Hex value of the key at (row, column).
    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b0000: code = 4'h1;
            4'b0001: code = 4'h2;
            4'b0010: code = 4'h3;
            4'b0011: code = 4'hA;
            4'b0100: code = 4'h4;
            4'b0101: code = 4'h5;
            4'b0110: code = 4'h6;
            4'b0111: code = 4'hB;
            4'b1000: code = 4'h7;
            4'b1001: code = 4'h8;
            4'b1010: code = 4'h9;
            4'b1011: code = 4'hC;
            4'b1100: code = 4'h0;
            4'b1101: code = 4'hF;
            4'b1110: code = 4'hE;
            4'b1111: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Active-low drive pattern for a column index.
    function automatic logic [3:0] col_decode(input logic [1:0] c);
        logic [3:0] pat;
        case (c)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1101;
            2'd2:    pat = 4'b1011;
            2'd3:    pat = 4'b0111;
            default: pat = 4'b1110;
        endcase
        return pat;
    endfunction

    // Lowest-index pressed row wins when several rows are low together.
    function automatic logic [1:0] lowest_row(input logic [3:0] low);
        logic [1:0] r;
        if (low[0]) begin
            r = 2'd0;
        end else if (low[1]) begin
            r = 2'd1;
        end else if (low[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    assign row_low_s = ~row_sync_r;
    assign sel_low_s = row_low_s[row_sel_r];

    // Next-state, counter and output logic of the scan/debounce FSM.
    always_comb begin
        state_s   = state_r;
        col_s     = col_r;
        row_sel_s = row_sel_r;
        settle_s  = settle_cnt_r;
        deb_s     = deb_cnt_r;
        valid_s   = 1'b0;
        code_s    = key_code_r;
        down_s    = key_down_r;
`ifdef KYPD_REPEAT_EN
        rep_s     = rep_cnt_r;
`endif
        case (state_r)
            ST_SCAN: begin
                if (settle_cnt_r >= SW'(SETTLE_CYC - 1)) begin
                    settle_s = '0;
                    if (|row_low_s) begin
                        row_sel_s = lowest_row(row_low_s);
                        deb_s     = '0;
                        state_s   = ST_DEBOUNCE;
                    end else begin
                        col_s = col_r + 2'd1;
                    end
                end else begin
                    settle_s = settle_cnt_r + SW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!sel_low_s) begin
                    // Bounce: retry the same column from a fresh settle.
                    state_s  = ST_SCAN;
                    settle_s = '0;
                    deb_s    = '0;
                end else if (deb_cnt_r >= DW'(DEBOUNCE_CYC - 1)) begin
                    state_s = ST_HELD;
                    valid_s = 1'b1;
                    code_s  = map_key(row_sel_r, col_r);
                    down_s  = 1'b1;
                    deb_s   = '0;
`ifdef KYPD_REPEAT_EN
                    rep_s   = '0;
`endif
                end else begin
                    deb_s = deb_cnt_r + DW'(1);
                end
            end
            ST_HELD: begin
                if (!sel_low_s) begin
                    state_s = ST_RELEASE;
                    deb_s   = '0;
                end else begin
                    state_s = ST_HELD;
`ifdef KYPD_REPEAT_EN
                    if (rep_cnt_r >= RW'(REPEAT_CYC - 1)) begin
                        valid_s = 1'b1;
                        rep_s   = '0;
                    end else begin
                        rep_s = rep_cnt_r + RW'(1);
                    end
`endif
                end
            end
            ST_RELEASE: begin
                if (sel_low_s) begin
                    state_s = ST_HELD;
                    deb_s   = '0;
`ifdef KYPD_REPEAT_EN
                    rep_s   = '0;
`endif
                end else if (deb_cnt_r >= DW'(DEBOUNCE_CYC - 1)) begin
                    state_s  = ST_SCAN;
                    down_s   = 1'b0;
                    col_s    = col_r + 2'd1;
                    settle_s = '0;
                    deb_s    = '0;
                end else begin
                    deb_s = deb_cnt_r + DW'(1);
                end
            end
            default: begin
                state_s  = ST_SCAN;
                col_s    = 2'd0;
                settle_s = '0;
                deb_s    = '0;
            end
        endcase
    end

    // Row synchronizer, FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_r   <= 4'h0;
            row_sync_r   <= 4'h0;
            state_r      <= ST_SCAN;
            col_r        <= 2'd0;
            row_sel_r    <= 2'd0;
            settle_cnt_r <= '0;
            deb_cnt_r    <= '0;
            col_n_r      <= 4'b1110;
            key_valid_r  <= 1'b0;
            key_code_r   <= 4'h0;
            key_down_r   <= 1'b0;
`ifdef KYPD_REPEAT_EN
            rep_cnt_r    <= '0;
`endif
        end else begin
            row_meta_r   <= row_n;
            row_sync_r   <= row_meta_r;
            state_r      <= state_s;
            col_r        <= col_s;
            row_sel_r    <= row_sel_s;
            settle_cnt_r <= settle_s;
            deb_cnt_r    <= deb_s;
            col_n_r      <= col_decode(col_s);
            key_valid_r  <= valid_s;
            key_code_r   <= code_s;
            key_down_r   <= down_s;
`ifdef KYPD_REPEAT_EN
            rep_cnt_r    <= rep_s;
`endif
        end
    end

    assign col_n     = col_n_r;
    assign key_valid = key_valid_r;
    assign key_code  = key_code_r;
    assign key_down  = key_down_r;

endmodule
